// File: rtl/data_mem_responder.sv
// data_mem_responder: valid/ready load/store responder in front of a 20-bit word array, with WAIT_CYCLES wait states.
// Defining PARITY_EN stores an even-parity bit per word; a load that finds a parity mismatch reports rsp_err.
module data_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [19:0] req_addr,
  input  logic [19:0] req_wdata,
  input  logic        par_inject,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [19:0] rsp_rdata,
  output logic        rsp_err
);
`ifdef PARITY_EN
  localparam int DW = 21;
`else
  localparam int DW = 20;
`endif
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, nxt;
  logic [3:0] wcnt;
  logic we_q;
  logic [19:0] addr_q, wdata_q;
  logic [DW-1:0] mem [2**ADDR_W];
  logic acc, go, a_we, a_inr, perr;
  logic [19:0] a_addr, a_wdata;
  logic [DW-1:0] word, wr_word;
  assign acc = req_valid && req_ready;
  // With no wait states the access happens on the accept edge, so it uses the live request.
  assign go = (acc && WAIT_CYCLES == 0) || (state == WAIT && wcnt == 4'd1);
  assign a_we = state == IDLE ? req_we : we_q;
  assign a_addr = state == IDLE ? req_addr : addr_q;
  assign a_wdata = state == IDLE ? req_wdata : wdata_q;
  assign a_inr = (a_addr >> ADDR_W) == 20'd0;
  assign word = mem[a_addr[ADDR_W-1:0]];
  assign rsp_valid = state == RESP;
`ifdef PARITY_EN
  logic inj_q;
  assign wr_word = {^a_wdata ^ (state == IDLE ? par_inject : inj_q), a_wdata};
  assign perr = ^word;
  always_ff @(posedge clk or negedge reset)
    if (!reset) inj_q <= 1'b0;
    else if (acc) inj_q <= par_inject;
`else
  logic unused_inj;
  assign unused_inj = par_inject;
  assign wr_word = a_wdata;
  assign perr = 1'b0;
`endif
  always_comb begin
    nxt = state;
    if (acc) nxt = WAIT_CYCLES == 0 ? RESP : WAIT;
    else if (go) nxt = RESP;
    else if (state == RESP && rsp_ready) nxt = IDLE;
  end
  // req_ready is registered, so it rises one cycle after the FSM settles back in IDLE.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      req_ready <= 1'b1;
      wcnt <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= nxt;
      req_ready <= state == IDLE && nxt == IDLE;
      if (acc) begin
        wcnt <= 4'(WAIT_CYCLES);
        we_q <= req_we;
        addr_q <= req_addr;
        wdata_q <= req_wdata;
      end else if (state == WAIT) wcnt <= wcnt - 4'd1;
      if (go) begin
        rsp_rdata <= (a_we || !a_inr) ? 20'd0 : word[19:0];
        rsp_err <= !a_inr || (!a_we && perr);
      end
    end
  always_ff @(posedge clk)
    if (go && a_we && a_inr) mem[a_addr[ADDR_W-1:0]] <= wr_word;
endmodule
